// File: rtl/alu_op_decoder.sv
// ============================================================================
//  Module   : alu_op_decoder
//  Brief    : RV32I execute-stage issue unit. It decodes the ALU opcode, selects
//             operand B, and presents a registered valid/ready output backed
//             by a 1-entry skid buffer. Optional macro ALU_DEC_PERF_EN adds
//             perf_issued and perf_illegal transfer counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_decoder #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [OP_W-1:0]   out_alu_op,
  output logic [4:0]        out_rd,
  output logic              out_is_mem,
`ifdef ALU_DEC_PERF_EN
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_illegal,
`endif
  output logic              out_illegal
);

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;

  localparam logic [OP_W-1:0] c_ALU_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] c_ALU_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] c_ALU_AND = OP_W'(2);
  localparam logic [OP_W-1:0] c_ALU_OR  = OP_W'(3);
  localparam logic [OP_W-1:0] c_ALU_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] c_ALU_SLL = OP_W'(5);
  localparam logic [OP_W-1:0] c_ALU_SRL = OP_W'(6);

  // Entry layout: {illegal, is_mem, rd, alu_op, b, a}
  localparam int ENTRY_W = 2*DATA_W + OP_W + 5 + 2;

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic [DATA_W-1:0] w_imm_i;
  logic [DATA_W-1:0] w_imm_s;
  logic [DATA_W-1:0] w_shamt;

  assign w_opcode = in_inst[6:0];
  assign w_funct3 = in_inst[14:12];
  assign w_funct7 = in_inst[31:25];
  assign w_imm_i  = {{(DATA_W-12){in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s  = {{(DATA_W-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_shamt  = {{(DATA_W-5){1'b0}}, in_inst[24:20]};

  // Register-file indices are resolved upstream; only their data arrives here.
  logic w_unused_rs_idx;
  assign w_unused_rs_idx = &{1'b0, in_inst[19:15]};

  logic              w_legal;
  logic [OP_W-1:0]   w_op;
  logic [DATA_W-1:0] w_b;
  logic              w_is_mem;
  logic              w_is_store;

  always_comb begin
    w_legal    = 1'b0;
    w_op       = c_ALU_ADD;
    w_b        = in_rs2_data;
    w_is_mem   = 1'b0;
    w_is_store = 1'b0;
    case (w_opcode)
      c_OPC_OP: begin
        w_b = in_rs2_data;
        if (w_funct7 == 7'b0000000) begin
          w_legal = 1'b1;
          case (w_funct3)
            3'b000:  w_op = c_ALU_ADD;
            3'b001:  w_op = c_ALU_SLL;
            3'b100:  w_op = c_ALU_XOR;
            3'b101:  w_op = c_ALU_SRL;
            3'b110:  w_op = c_ALU_OR;
            3'b111:  w_op = c_ALU_AND;
            default: w_legal = 1'b0;
          endcase
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
          w_legal = 1'b1;
          w_op    = c_ALU_SUB;
        end
      end
      c_OPC_OP_IMM: begin
        w_b     = w_imm_i;
        w_legal = 1'b1;
        case (w_funct3)
          3'b000: w_op = c_ALU_ADD;
          3'b100: w_op = c_ALU_XOR;
          3'b110: w_op = c_ALU_OR;
          3'b111: w_op = c_ALU_AND;
          3'b001: begin
            w_op    = c_ALU_SLL;
            w_b     = w_shamt;
            w_legal = (w_funct7 == 7'b0000000);
          end
          3'b101: begin
            w_op    = c_ALU_SRL;
            w_b     = w_shamt;
            w_legal = (w_funct7 == 7'b0000000);
          end
          default: w_legal = 1'b0;
        endcase
      end
      c_OPC_LOAD: begin
        w_legal  = 1'b1;
        w_op     = c_ALU_ADD;
        w_b      = w_imm_i;
        w_is_mem = 1'b1;
      end
      c_OPC_STORE: begin
        w_legal    = 1'b1;
        w_op       = c_ALU_ADD;
        w_b        = w_imm_s;
        w_is_mem   = 1'b1;
        w_is_store = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal entries carry zeroed operands/opcode but keep rd for traceability.
  logic [ENTRY_W-1:0] w_entry;
  always_comb begin
    if (w_legal) begin
      w_entry = {1'b0, w_is_mem, (w_is_store ? 5'd0 : in_inst[11:7]),
                 w_op, w_b, in_rs1_data};
    end else begin
      w_entry = {1'b1, 1'b0, in_inst[11:7], c_ALU_ADD,
                 {DATA_W{1'b0}}, {DATA_W{1'b0}}};
    end
  end

  logic [ENTRY_W-1:0] r_main;
  logic [ENTRY_W-1:0] r_skid;
  logic               r_main_valid;
  logic               r_skid_valid;
  logic               w_accept;
  logic               w_drain;

  assign in_ready = ~r_skid_valid;
  assign w_accept = in_valid & ~r_skid_valid;
  assign w_drain  = r_main_valid & out_ready;

  // The skid can only hold an entry while main is full, so main-empty implies skid-empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (!r_main_valid) begin
        if (w_accept) begin
          r_main       <= w_entry;
          r_main_valid <= 1'b1;
        end
      end else if (w_drain) begin
        if (r_skid_valid) begin
          r_main       <= r_skid;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_main <= w_entry;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid       <= w_entry;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign out_valid   = r_main_valid;
  assign out_a       = r_main[DATA_W-1:0];
  assign out_b       = r_main[2*DATA_W-1:DATA_W];
  assign out_alu_op  = r_main[2*DATA_W+OP_W-1:2*DATA_W];
  assign out_rd      = r_main[2*DATA_W+OP_W+4:2*DATA_W+OP_W];
  assign out_is_mem  = r_main[ENTRY_W-2];
  assign out_illegal = r_main[ENTRY_W-1];

`ifdef ALU_DEC_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_issued  <= '0;
      r_perf_illegal <= '0;
    end else if (w_drain) begin
      r_perf_issued <= r_perf_issued + 32'd1;
      if (out_illegal) begin
        r_perf_illegal <= r_perf_illegal + 32'd1;
      end
    end
  end

  assign perf_issued  = r_perf_issued;
  assign perf_illegal = r_perf_illegal;
`endif

endmodule

`default_nettype wire
